// File: rtl/alu_reservation_station_if.sv
// Dispatch, bypass and issue buses of the ALU reservation station.
// The lsb2rs_* wires exist only when RS_LSB_BYPASS_EN is defined.
interface alu_reservation_station_if #(
    parameter int ROB_W  = 4,
    parameter int TYPE_W = 6
);
    logic              dsp2rs_enable;
    logic [TYPE_W-1:0] dsp2rs_ins_type;
    logic              dsp2rs_rs1_ready;
    logic              dsp2rs_rs2_ready;
    logic [31:0]       dsp2rs_rs1_val;
    logic [31:0]       dsp2rs_rs2_val;
    logic [ROB_W-1:0]  dsp2rs_rs1_tag;
    logic [ROB_W-1:0]  dsp2rs_rs2_tag;
    logic [31:0]       dsp2rs_imm;
    logic [31:0]       dsp2rs_pc;
    logic [ROB_W-1:0]  dsp2rs_reorder;
    logic              rs2dsp_full;

    logic              alu2rs_bypass_enable;
    logic [ROB_W-1:0]  alu2rs_bypass_reorder;
    logic [31:0]       alu2rs_bypass_value;
`ifdef RS_LSB_BYPASS_EN
    logic              lsb2rs_enable;
    logic [ROB_W-1:0]  lsb2rs_reorder;
    logic [31:0]       lsb2rs_value;
`endif

    logic              rs2alu_enable;
    logic [31:0]       rs2alu_rs1;
    logic [31:0]       rs2alu_rs2;
    logic [31:0]       rs2alu_imm;
    logic [31:0]       rs2alu_pc;
    logic [TYPE_W-1:0] rs2alu_ins_type;
    logic [ROB_W-1:0]  rs2alu_reorder;

    // Reservation-station side
    modport slave (
        input  dsp2rs_enable, dsp2rs_ins_type, dsp2rs_rs1_ready, dsp2rs_rs2_ready,
               dsp2rs_rs1_val, dsp2rs_rs2_val, dsp2rs_rs1_tag, dsp2rs_rs2_tag,
               dsp2rs_imm, dsp2rs_pc, dsp2rs_reorder,
               alu2rs_bypass_enable, alu2rs_bypass_reorder, alu2rs_bypass_value,
`ifdef RS_LSB_BYPASS_EN
               lsb2rs_enable, lsb2rs_reorder, lsb2rs_value,
`endif
        output rs2dsp_full,
               rs2alu_enable, rs2alu_rs1, rs2alu_rs2, rs2alu_imm, rs2alu_pc,
               rs2alu_ins_type, rs2alu_reorder
    );

    // Dispatch / ALU / LSB side
    modport master (
        output dsp2rs_enable, dsp2rs_ins_type, dsp2rs_rs1_ready, dsp2rs_rs2_ready,
               dsp2rs_rs1_val, dsp2rs_rs2_val, dsp2rs_rs1_tag, dsp2rs_rs2_tag,
               dsp2rs_imm, dsp2rs_pc, dsp2rs_reorder,
               alu2rs_bypass_enable, alu2rs_bypass_reorder, alu2rs_bypass_value,
`ifdef RS_LSB_BYPASS_EN
               lsb2rs_enable, lsb2rs_reorder, lsb2rs_value,
`endif
        input  rs2dsp_full,
               rs2alu_enable, rs2alu_rs1, rs2alu_rs2, rs2alu_imm, rs2alu_pc,
               rs2alu_ins_type, rs2alu_reorder
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are ready,
// issues one per cycle. Define RS_LSB_BYPASS_EN to also snoop the LSB result bus.
module alu_rs_entry #(
    parameter int ROB_W  = 4,
    parameter int TYPE_W = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clear,
    input  logic              rdy,
    input  logic              alloc,
    input  logic              issue,
    input  logic [TYPE_W-1:0] in_type,
    input  logic              in_q1,
    input  logic              in_q2,
    input  logic [31:0]       in_v1,
    input  logic [31:0]       in_v2,
    input  logic [ROB_W-1:0]  in_t1,
    input  logic [ROB_W-1:0]  in_t2,
    input  logic [31:0]       in_imm,
    input  logic [31:0]       in_pc,
    input  logic [ROB_W-1:0]  in_rob,
    input  logic              alu_en,
    input  logic [ROB_W-1:0]  alu_tag,
    input  logic [31:0]       alu_val,
`ifdef RS_LSB_BYPASS_EN
    input  logic              lsb_en,
    input  logic [ROB_W-1:0]  lsb_tag,
    input  logic [31:0]       lsb_val,
`endif
    output logic              busy,
    output logic              ready,
    output logic [TYPE_W-1:0] ins_type,
    output logic [31:0]       v1,
    output logic [31:0]       v2,
    output logic [31:0]       imm,
    output logic [31:0]       pc,
    output logic [ROB_W-1:0]  rob
);
    logic             q1, q2;
    logic [ROB_W-1:0] t1, t2;

    // Snoop whichever operand source is about to land: dispatch on alloc, else stored state
    logic             src_q1, src_q2;
    logic [31:0]      src_v1, src_v2;
    logic [ROB_W-1:0] src_t1, src_t2;
    logic             alu_hit1, alu_hit2, lsb_hit1, lsb_hit2;
    logic [31:0]      lsb_data;
    logic             nxt_q1, nxt_q2;
    logic [31:0]      nxt_v1, nxt_v2;

    assign src_q1 = alloc ? in_q1 : q1;
    assign src_q2 = alloc ? in_q2 : q2;
    assign src_v1 = alloc ? in_v1 : v1;
    assign src_v2 = alloc ? in_v2 : v2;
    assign src_t1 = alloc ? in_t1 : t1;
    assign src_t2 = alloc ? in_t2 : t2;

    assign alu_hit1 = alu_en && (src_t1 == alu_tag);
    assign alu_hit2 = alu_en && (src_t2 == alu_tag);
`ifdef RS_LSB_BYPASS_EN
    assign lsb_hit1 = lsb_en && (src_t1 == lsb_tag);
    assign lsb_hit2 = lsb_en && (src_t2 == lsb_tag);
    assign lsb_data = lsb_val;
`else
    assign lsb_hit1 = 1'b0;
    assign lsb_hit2 = 1'b0;
    assign lsb_data = 32'd0;
`endif

    // ALU value wins when both buses carry the same tag
    assign nxt_q1 = src_q1 | alu_hit1 | lsb_hit1;
    assign nxt_q2 = src_q2 | alu_hit2 | lsb_hit2;
    assign nxt_v1 = src_q1 ? src_v1 : alu_hit1 ? alu_val : lsb_hit1 ? lsb_data : src_v1;
    assign nxt_v2 = src_q2 ? src_v2 : alu_hit2 ? alu_val : lsb_hit2 ? lsb_data : src_v2;

    assign ready = busy && q1 && q2;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy     <= 1'b0;
            q1       <= 1'b0;
            q2       <= 1'b0;
            v1       <= '0;
            v2       <= '0;
            t1       <= '0;
            t2       <= '0;
            ins_type <= '0;
            imm      <= '0;
            pc       <= '0;
            rob      <= '0;
        end else if (clear) begin
            busy <= 1'b0;
        end else if (rdy) begin
            if (alloc) begin
                busy     <= 1'b1;
                ins_type <= in_type;
                imm      <= in_imm;
                pc       <= in_pc;
                rob      <= in_rob;
                t1       <= in_t1;
                t2       <= in_t2;
            end else if (issue) begin
                busy <= 1'b0;
            end
            if (alloc || busy) begin
                q1 <= nxt_q1;
                q2 <= nxt_q2;
                v1 <= nxt_v1;
                v2 <= nxt_v2;
            end
        end
    end
endmodule

module alu_reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4,
    parameter int TYPE_W  = 6
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob2rs_clear,
    alu_reservation_station_if.slave rs_if
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]             busy, ready, alloc_vec, issue_vec;
    logic [RS_SIZE-1:0][TYPE_W-1:0] e_type;
    logic [RS_SIZE-1:0][31:0]       e_v1, e_v2, e_imm, e_pc;
    logic [RS_SIZE-1:0][ROB_W-1:0]  e_rob;

    logic             full, alloc_any, issue_any;
    logic [IDX_W-1:0] alloc_idx, issue_idx;

    logic              out_en;
    logic [31:0]       out_rs1, out_rs2, out_imm, out_pc;
    logic [TYPE_W-1:0] out_type;
    logic [ROB_W-1:0]  out_rob;

    // Full reflects registered occupancy only; a slot freed this cycle shows up next cycle
    assign full              = &busy;
    assign rs_if.rs2dsp_full = full;

    always_comb begin
        alloc_idx = '0;
        issue_idx = '0;
        alloc_any = 1'b0;
        issue_any = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_idx = IDX_W'(i);
                alloc_any = 1'b1;
            end
            if (ready[i]) begin
                issue_idx = IDX_W'(i);
                issue_any = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
        assign alloc_vec[g] = rs_if.dsp2rs_enable && alloc_any && (alloc_idx == IDX_W'(g));
        assign issue_vec[g] = issue_any && (issue_idx == IDX_W'(g));

        alu_rs_entry #(
            .ROB_W  (ROB_W),
            .TYPE_W (TYPE_W)
        ) u_ent (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .clear    (rob2rs_clear),
            .rdy      (rdy_in),
            .alloc    (alloc_vec[g]),
            .issue    (issue_vec[g]),
            .in_type  (rs_if.dsp2rs_ins_type),
            .in_q1    (rs_if.dsp2rs_rs1_ready),
            .in_q2    (rs_if.dsp2rs_rs2_ready),
            .in_v1    (rs_if.dsp2rs_rs1_val),
            .in_v2    (rs_if.dsp2rs_rs2_val),
            .in_t1    (rs_if.dsp2rs_rs1_tag),
            .in_t2    (rs_if.dsp2rs_rs2_tag),
            .in_imm   (rs_if.dsp2rs_imm),
            .in_pc    (rs_if.dsp2rs_pc),
            .in_rob   (rs_if.dsp2rs_reorder),
            .alu_en   (rs_if.alu2rs_bypass_enable),
            .alu_tag  (rs_if.alu2rs_bypass_reorder),
            .alu_val  (rs_if.alu2rs_bypass_value),
`ifdef RS_LSB_BYPASS_EN
            .lsb_en   (rs_if.lsb2rs_enable),
            .lsb_tag  (rs_if.lsb2rs_reorder),
            .lsb_val  (rs_if.lsb2rs_value),
`endif
            .busy     (busy[g]),
            .ready    (ready[g]),
            .ins_type (e_type[g]),
            .v1       (e_v1[g]),
            .v2       (e_v2[g]),
            .imm      (e_imm[g]),
            .pc       (e_pc[g]),
            .rob      (e_rob[g])
        );
    end

    // Issue register; while stalled the payload holds and only enable drops
    always_ff @(posedge clk_in) begin
        if (rst_in || rob2rs_clear) begin
            out_en   <= 1'b0;
            out_rs1  <= '0;
            out_rs2  <= '0;
            out_imm  <= '0;
            out_pc   <= '0;
            out_type <= '0;
            out_rob  <= '0;
        end else if (!rdy_in) begin
            out_en <= 1'b0;
        end else if (issue_any) begin
            out_en   <= 1'b1;
            out_rs1  <= e_v1[issue_idx];
            out_rs2  <= e_v2[issue_idx];
            out_imm  <= e_imm[issue_idx];
            out_pc   <= e_pc[issue_idx];
            out_type <= e_type[issue_idx];
            out_rob  <= e_rob[issue_idx];
        end else begin
            out_en   <= 1'b0;
            out_rs1  <= '0;
            out_rs2  <= '0;
            out_imm  <= '0;
            out_pc   <= '0;
            out_type <= '0;
            out_rob  <= '0;
        end
    end

    assign rs_if.rs2alu_enable   = out_en;
    assign rs_if.rs2alu_rs1      = out_rs1;
    assign rs_if.rs2alu_rs2      = out_rs2;
    assign rs_if.rs2alu_imm      = out_imm;
    assign rs_if.rs2alu_pc       = out_pc;
    assign rs_if.rs2alu_ins_type = out_type;
    assign rs_if.rs2alu_reorder  = out_rob;
endmodule
